gpio_ext: RTL and testbench

- Next-generation parametrised GPIO peripheral on the simple register bus (addr/we/wd/rd).
- Per pin it provides:
  - a configurable-depth input synchroniser;
  - an optional debounce filter with a shared prescaler;
  - atomic set/clear/toggle of outputs;
  - per-pin interrupt mode: rising, falling, both edges, level-high or level-low.
- Latched interrupt status is write-1-to-clear; the single `irq` output goes to the system interrupt controller.

---
 rtl/gpio_ext.sv | 180 ++++++++++++++++++
 tb/tb_gpio_ext.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ext.sv
// Parametrised GPIO peripheral on the simple register bus: input synchroniser,
// debounce filter with shared prescaler, atomic output ops and latched interrupts.
module gpio_ext #(
  parameter int GPIO_W     = 8,
  parameter int SYNC_DEPTH = 2,
  parameter int DB_LEN     = 4,
  parameter int PRESC_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        addr,
  input  logic              we,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  output logic              irq,
  input  logic [GPIO_W-1:0] gpi,
  output logic [GPIO_W-1:0] gpo,
  output logic [GPIO_W-1:0] gpd
);

  localparam int DBC_W = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;

  typedef enum logic [3:0] {
    A_GPI  = 4'h0, A_GPO  = 4'h1, A_SET  = 4'h2, A_CLR  = 4'h3,
    A_TGL  = 4'h4, A_GPD  = 4'h5, A_MSK  = 4'h6, A_TYPE = 4'h7,
    A_POL  = 4'h8, A_BOTH = 4'h9, A_V    = 4'hA, A_DEN  = 4'hB,
    A_DIV  = 4'hC
  } reg_addr_e;

  reg_addr_e         idx;
  logic [GPIO_W-1:0] wdat;
  logic              unused_bits;

  assign idx         = reg_addr_e'(addr[5:2]);
  assign wdat        = wd[GPIO_W-1:0];
  assign unused_bits = ^{wd, addr[1:0]};

  logic [GPIO_W-1:0]  gpo_q, gpo_d, gpd_q, gpd_d, msk_q, msk_d, typ_q, typ_d;
  logic [GPIO_W-1:0]  pol_q, pol_d, both_q, both_d, irqv_q, irqv_d, den_q, den_d;
  logic [PRESC_W-1:0] div_q, div_d, presc_q, presc_d;
  logic [GPIO_W-1:0]  sync_q [SYNC_DEPTH];
  logic [GPIO_W-1:0]  filt_q, filt_d, prev_q;
  logic [DBC_W-1:0]   dbc_q [GPIO_W];
  logic [DBC_W-1:0]   dbc_d [GPIO_W];
  logic               irq_q;

  logic               tick;
  logic [GPIO_W-1:0]  sync, den_tgl, rise, fall, edge_ev, lvl_ev, evt;

  assign sync = sync_q[SYNC_DEPTH-1];
  assign tick = (presc_q == div_q);

  // Register writes, prescaler and status next-state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gpo_d  = gpo_q;
    gpd_d  = gpd_q;
    msk_d  = msk_q;
    typ_d  = typ_q;
    pol_d  = pol_q;
    both_d = both_q;
    den_d  = den_q;
    div_d  = div_q;
    irqv_d = irqv_q;
    if (we) begin
      case (idx)
        A_GPO:   gpo_d  = wdat;
        A_SET:   gpo_d  = gpo_q | wdat;
        A_CLR:   gpo_d  = gpo_q & ~wdat;
        A_TGL:   gpo_d  = gpo_q ^ wdat;
        A_GPD:   gpd_d  = wdat;
        A_MSK:   msk_d  = wdat;
        A_TYPE:  typ_d  = wdat;
        A_POL:   pol_d  = wdat;
        A_BOTH:  both_d = wdat;
        A_V:     irqv_d = irqv_q & ~wdat;
        A_DEN:   den_d  = wdat;
        A_DIV:   div_d  = wd[PRESC_W-1:0];
        default: ;
      endcase
    end
    // Events are OR-ed in after the clear so a new event wins over W1C.
    irqv_d = irqv_d | evt;

    if (we && idx == A_DIV) presc_d = '0;
    else if (tick)          presc_d = '0;
    else                    presc_d = presc_q + PRESC_W'(1);
  end

  assign den_tgl = (we && idx == A_DEN) ? (wdat ^ den_q) : '0;

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < GPIO_W; i++) begin
      dbc_d[i] = dbc_q[i];
      if (!den_q[i]) begin
        filt_d[i] = sync[i];
        dbc_d[i]  = '0;
      end else if (sync[i] == filt_q[i]) begin
        dbc_d[i] = '0;
      end else if (tick) begin
        if (dbc_q[i] == DBC_W'(DB_LEN - 1)) begin
          filt_d[i] = sync[i];
          dbc_d[i]  = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + DBC_W'(1);
        end
      end
      if (den_tgl[i]) dbc_d[i] = '0;
    end
  end

  assign rise    = filt_q & ~prev_q;
  assign fall    = ~filt_q & prev_q;
  assign edge_ev = (both_q & (rise | fall)) | (~both_q & ((pol_q & rise) | (~pol_q & fall)));
  assign lvl_ev  = ~(filt_q ^ pol_q);
  assign evt     = msk_q & ((typ_q & lvl_ev) | (~typ_q & edge_ev));

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpo_q   <= '0;
      gpd_q   <= '0;
      msk_q   <= '0;
      typ_q   <= '0;
      pol_q   <= '0;
      both_q  <= '0;
      irqv_q  <= '0;
      den_q   <= '0;
      div_q   <= '0;
      presc_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
      // NOTE: the synchroniser and filter-counter arrays are reset too, so a
      // reset mid-debounce leaves no stale state behind.
      for (int k = 0; k < SYNC_DEPTH; k++) sync_q[k] <= '0;
      for (int i = 0; i < GPIO_W; i++)     dbc_q[i]  <= '0;
    end else begin
      gpo_q   <= gpo_d;
      gpd_q   <= gpd_d;
      msk_q   <= msk_d;
      typ_q   <= typ_d;
      pol_q   <= pol_d;
      both_q  <= both_d;
      irqv_q  <= irqv_d;
      den_q   <= den_d;
      div_q   <= div_d;
      presc_q <= presc_d;
      filt_q  <= filt_d;
      prev_q  <= filt_q;
      irq_q   <= |irqv_q;
      sync_q[0] <= gpi;
      for (int k = 1; k < SYNC_DEPTH; k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < GPIO_W; i++)     dbc_q[i]  <= dbc_d[i];
    end
  end

  always_comb begin
    rd = '0;
    case (idx)
      A_GPI:   rd[GPIO_W-1:0]  = filt_q;
      A_GPO:   rd[GPIO_W-1:0]  = gpo_q;
      A_GPD:   rd[GPIO_W-1:0]  = gpd_q;
      A_MSK:   rd[GPIO_W-1:0]  = msk_q;
      A_TYPE:  rd[GPIO_W-1:0]  = typ_q;
      A_POL:   rd[GPIO_W-1:0]  = pol_q;
      A_BOTH:  rd[GPIO_W-1:0]  = both_q;
      A_V:     rd[GPIO_W-1:0]  = irqv_q;
      A_DEN:   rd[GPIO_W-1:0]  = den_q;
      A_DIV:   rd[PRESC_W-1:0] = div_q;
      default: rd = '0;
    endcase
  end

  assign gpo = gpo_q;
  assign gpd = gpd_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_gpio_ext.sv
// Directed self-checking bench for gpio_ext with default parameters
// (GPIO_W=8, SYNC_DEPTH=2, DB_LEN=4, PRESC_W=16).
module tb_gpio_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  logic [7:0]  gpi;
  logic [7:0]  gpo;
  logic [7:0]  gpd;

  int checks = 0;
  int errors = 0;

  gpio_ext dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq),
    .gpi  (gpi),
    .gpo  (gpo),
    .gpd  (gpd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Bus write presented between two falling edges; returns after the write edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    we   = 1'b0;
    addr = '0;
    wd   = '0;
    gpi  = 8'hFF;

    // Reset state
    cyc(3);
    for (int a = 0; a < 13; a++) rdchk($sformatf("rst_rd_%0h", a * 4), 6'(a * 4), 32'h0);
    check("rst_gpo", {24'h0, gpo}, 32'h0);
    check("rst_gpd", {24'h0, gpd}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    cyc(4);
    rdchk("gpi_ff", 6'h00, 32'hFF);
    gpi = 8'h00;
    cyc(4);
    rdchk("gpi_00", 6'h00, 32'h00);

    // Readback
    wr(6'h04, 32'hA5);
    wr(6'h14, 32'h0F);
    rdchk("gpo_rd", 6'h04, 32'hA5);
    rdchk("gpd_rd", 6'h14, 32'h0F);
    check("gpo_pin", {24'h0, gpo}, 32'hA5);
    check("gpd_pin", {24'h0, gpd}, 32'h0F);
    rdchk("wo_set_rd", 6'h08, 32'h0);
    rdchk("unmapped_rd", 6'h34, 32'h0);

    // Atomic output ops
    wr(6'h08, 32'h0A);
    check("gpo_set", {24'h0, gpo}, 32'hAF);
    wr(6'h0C, 32'h81);
    check("gpo_clr", {24'h0, gpo}, 32'h2E);
    wr(6'h10, 32'hFF);
    check("gpo_tgl", {24'h0, gpo}, 32'hD1);
    rdchk("gpo_tgl_rd", 6'h04, 32'hD1);

    // Rising edge on pin 0, latency from the edge where gpi changes
    wr(6'h18, 32'h01);
    wr(6'h20, 32'h01);
    cyc(1);
    @(posedge clk); #1 gpi[0] = 1'b1;
    cyc(2);
    rdchk("rise_gpi_e2", 6'h00, 32'h00);
    cyc(1);
    rdchk("rise_gpi_e3", 6'h00, 32'h01);
    rdchk("rise_v_e3", 6'h28, 32'h00);
    cyc(1);
    rdchk("rise_v_e4", 6'h28, 32'h01);
    check("rise_irq_e4", {31'h0, irq}, 32'h0);
    cyc(1);
    check("rise_irq_e5", {31'h0, irq}, 32'h1);
    wr(6'h28, 32'h01);
    rdchk("w1c_v", 6'h28, 32'h00);
    check("w1c_irq_still", {31'h0, irq}, 32'h1);
    cyc(1);
    check("w1c_irq_clr", {31'h0, irq}, 32'h0);
    gpi[0] = 1'b0;
    cyc(6);
    rdchk("fall_no_v", 6'h28, 32'h00);
    check("fall_no_irq", {31'h0, irq}, 32'h0);

    // Both edges on pin 1
    wr(6'h18, 32'h02);
    wr(6'h24, 32'h02);
    gpi[1] = 1'b1;
    cyc(6);
    rdchk("both_rise", 6'h28, 32'h02);
    wr(6'h28, 32'h02);
    rdchk("both_rise_clr", 6'h28, 32'h00);
    gpi[1] = 1'b0;
    cyc(6);
    rdchk("both_fall", 6'h28, 32'h02);
    wr(6'h28, 32'h02);
    rdchk("both_fall_clr", 6'h28, 32'h00);

    // Level-low on pin 2
    wr(6'h1C, 32'h04);
    wr(6'h18, 32'h04);
    cyc(2);
    rdchk("lvl_set", 6'h28, 32'h04);
    wr(6'h28, 32'h04);
    rdchk("lvl_clr_blocked", 6'h28, 32'h04);
    gpi[2] = 1'b1;
    cyc(6);
    rdchk("lvl_latched", 6'h28, 32'h04);
    wr(6'h28, 32'h04);
    rdchk("lvl_clr_ok", 6'h28, 32'h00);
    cyc(1);
    check("lvl_irq_clr", {31'h0, irq}, 32'h0);

    // Masked pin 3
    repeat (4) begin
      gpi[3] = ~gpi[3];
      cyc(3);
    end
    cyc(4);
    rdchk("mask_v", 6'h28, 32'h00);
    check("mask_irq", {31'h0, irq}, 32'h0);

    // Debounce on pin 0: tick every 4 cycles, 4 ticks required
    wr(6'h18, 32'h00);
    wr(6'h2C, 32'h01);
    wr(6'h30, 32'h3);
    rdchk("div_rd", 6'h30, 32'h3);
    rdchk("den_rd", 6'h2C, 32'h1);
    @(posedge clk); #1 gpi[0] = 1'b1;
    repeat (12) @(posedge clk);
    #1 gpi[0] = 1'b0;
    cyc(20);
    rdchk("dbnc_glitch", 6'h00, 32'h04);
    @(posedge clk); #1 gpi[0] = 1'b1;
    cyc(6);
    rdchk("dbnc_early", 6'h00, 32'h04);
    cyc(20);
    rdchk("dbnc_accept", 6'h00, 32'h05);

    // Event coincident with W1C of the same bit
    wr(6'h2C, 32'h00);
    gpi[0] = 1'b0;
    cyc(5);
    wr(6'h18, 32'h01);
    rdchk("sim_pre", 6'h28, 32'h00);
    @(posedge clk); #1 gpi[0] = 1'b1;
    cyc(3);
    addr = 6'h28;
    wd   = 32'h01;
    we   = 1'b1;
    @(posedge clk); #1 we = 1'b0;
    rdchk("set_wins", 6'h28, 32'h01);
    wr(6'h28, 32'h01);
    rdchk("set_wins_clr", 6'h28, 32'h00);

    // Reset with status pending and debounce counting
    gpi = 8'h00;
    cyc(4);
    wr(6'h1C, 32'hFF);
    wr(6'h20, 32'h00);
    wr(6'h18, 32'hFF);
    cyc(3);
    rdchk("pre_rst_v", 6'h28, 32'hFF);
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    wr(6'h2C, 32'h01);
    gpi = 8'h01;
    cyc(7);
    rdchk("pre_rst_dbnc", 6'h00, 32'h00);
    @(posedge clk); #1 rst = 1'b1;
    cyc(1);
    for (int a = 0; a < 13; a++) rdchk($sformatf("mid_rst_rd_%0h", a * 4), 6'(a * 4), 32'h0);
    check("mid_rst_gpo", {24'h0, gpo}, 32'h0);
    check("mid_rst_gpd", {24'h0, gpd}, 32'h0);
    check("mid_rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    cyc(5);
    rdchk("post_rst_gpi", 6'h00, 32'h01);
    rdchk("post_rst_v", 6'h28, 32'h00);
    check("post_rst_irq", {31'h0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
